div_sequencer: RTL and testbench

Multi-cycle controller for RV32M divide/remainder (DIV, DIVU, REM, REMU) in the EX stage of the 5-stage core. Accepts one operation from the ID/EX boundary and runs a 32-step restoring division. Holds the pipeline through the hazard unit's stall path until the result is ready, then presents the result, zero-division flag and signed-overflow flag to the EX/MEM register. Divide-by-zero and signed-overflow cases finish in one cycle.

---
 rtl/core_pkg.sv | 28 ++
 rtl/div_sequencer_if.sv | 28 ++
 rtl/div_sequencer_step.sv | 22 ++
 rtl/div_sequencer.sv | 162 ++++++++++++++++
 tb/tb_div_sequencer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core definitions used by the divide sequencer: data width,
// RV32M divide funct3 codes, FSM encoding and funct3 decode helpers.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] FUNCT3_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110;
    localparam logic [2:0] FUNCT3_REMU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Codes outside the four divide ops decode as DIVU: unsigned, quotient.
    function automatic logic is_signed_op(input logic [2:0] f3);
        return (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
    endfunction

    function automatic logic is_rem_op(input logic [2:0] f3);
        return (f3 == FUNCT3_REM) || (f3 == FUNCT3_REMU);
    endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// EX-stage divide unit bundle: request and operands from ID/EX, stall to
// the hazard unit, result and flags towards EX/MEM.
interface div_sequencer_if;
    import core_pkg::*;

    logic            Start;
    logic [2:0]      Funct3;
    logic [XLEN-1:0] Dividend;
    logic [XLEN-1:0] Divisor;
    logic            Flush;
    logic            Stall;
    logic            Busy;
    logic            Done;
    logic [XLEN-1:0] Result;
    logic            ZeroDivision;
    logic            OverflowSignedDiv;

    modport master (
        output Start, Funct3, Dividend, Divisor, Flush,
        input  Stall, Busy, Done, Result, ZeroDivision, OverflowSignedDiv
    );

    modport slave (
        input  Start, Funct3, Dividend, Divisor, Flush,
        output Stall, Busy, Done, Result, ZeroDivision, OverflowSignedDiv
    );

endinterface

// File: rtl/div_sequencer_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step
    import core_pkg::*;
(
    input  logic [XLEN:0]   rem_i,
    input  logic            dvd_msb_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN:0]   rem_o,
    output logic            quo_bit_o
);

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] trial;

    // A borrow out of the widened subtraction means the divisor did not fit.
    assign shifted   = {rem_i, dvd_msb_i};
    assign trial     = shifted - {2'b00, divisor_i};
    assign quo_bit_o = ~trial[XLEN+1];
    assign rem_o     = quo_bit_o ? trial[XLEN:0] : shifted[XLEN:0];

endmodule

// File: rtl/div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU controller: 32-step restoring division on operand
// magnitudes with a sign fix-up, single-cycle divide-by-zero and overflow.
module div_sequencer
    import core_pkg::*;
(
    input  logic          CLK,
    input  logic          RESET,
    div_sequencer_if.slave bus
);

    state_e          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [XLEN-1:0] dsr_q, dsr_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            zdiv_q, zdiv_d;
    logic            ovf_q, ovf_d;

    logic            start_signed;
    logic            dvd_neg, dsr_neg;
    logic [XLEN-1:0] dvd_abs, dsr_abs;
    logic            div_by_zero, signed_ovf, accept;
    logic [XLEN:0]   step_rem;
    logic            step_quo;
    logic [XLEN-1:0] quo_fix, rem_fix;

    assign start_signed = is_signed_op(bus.Funct3);
    assign dvd_neg      = start_signed & bus.Dividend[XLEN-1];
    assign dsr_neg      = start_signed & bus.Divisor[XLEN-1];
    assign dvd_abs      = dvd_neg ? -bus.Dividend : bus.Dividend;
    assign dsr_abs      = dsr_neg ? -bus.Divisor : bus.Divisor;
    assign div_by_zero  = (bus.Divisor == '0);
    assign signed_ovf   = start_signed && (bus.Dividend == 32'h8000_0000)
                          && (bus.Divisor == 32'hFFFF_FFFF);
    // A redirect in the same cycle kills the request before it is taken.
    assign accept       = bus.Start && !bus.Flush;

    div_step u_step (
        .rem_i     (rem_q),
        .dvd_msb_i (dvd_q[XLEN-1]),
        .divisor_i (dsr_q),
        .rem_o     (step_rem),
        .quo_bit_o (step_quo)
    );

    assign quo_fix = neg_quo_q ? -quo_q : quo_q;
    assign rem_fix = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path
        // through the case statement leaves one unassigned and infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        funct3_d  = funct3_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        result_d  = result_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        zdiv_d    = zdiv_q;
        ovf_d     = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    funct3_d  = bus.Funct3;
                    neg_quo_d = dvd_neg ^ dsr_neg;
                    neg_rem_d = dvd_neg;
                    zdiv_d    = 1'b0;
                    ovf_d     = 1'b0;
                    if (div_by_zero) begin
                        zdiv_d   = 1'b1;
                        result_d = is_rem_op(bus.Funct3) ? bus.Dividend : '1;
                        state_d  = ST_DONE;
                    end else if (signed_ovf) begin
                        ovf_d    = 1'b1;
                        result_d = is_rem_op(bus.Funct3) ? '0 : 32'h8000_0000;
                        state_d  = ST_DONE;
                    end else begin
                        dvd_d   = dvd_abs;
                        dsr_d   = dsr_abs;
                        quo_d   = '0;
                        rem_d   = '0;
                        cnt_d   = 5'd31;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[XLEN-2:0], 1'b0};
                quo_d = {quo_q[XLEN-2:0], step_quo};
                if (cnt_q == 5'd0) begin
                    state_d = ST_FIXUP;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ST_FIXUP: begin
                result_d = is_rem_op(funct3_q) ? rem_fix : quo_fix;
                state_d  = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // An aborted op must leave the previously presented result intact.
        if (bus.Flush && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            funct3_q  <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zdiv_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            funct3_q  <= funct3_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            zdiv_q    <= zdiv_d;
            ovf_q     <= ovf_d;
        end
    end

    // Stall drops in DONE so the pipeline advances and captures Result.
    assign bus.Stall             = ((state_q == ST_IDLE) && bus.Start)
                                   || (state_q == ST_RUN) || (state_q == ST_FIXUP);
    assign bus.Busy              = (state_q != ST_IDLE);
    assign bus.Done              = (state_q == ST_DONE);
    assign bus.Result            = result_q;
    assign bus.ZeroDivision      = zdiv_q;
    assign bus.OverflowSignedDiv = ovf_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed RV32M divide ops checked against an
// arithmetic reference model every cycle plus literal expected results.
module tb_div_sequencer;
    import core_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        zd;
        logic        ov;
        int          lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;
    bit   cmp_en;

    // Reference model state: the op in flight and what the outputs showed before it.
    int          m_k;
    int          m_done;
    int          m_abort;
    logic [31:0] m_old_res, m_new_res;
    logic        m_old_zd, m_new_zd, m_old_ov, m_new_ov;

    div_sequencer_if bus ();

    div_sequencer dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RISC-V divide semantics straight from the ISA rules.
    function automatic exp_t model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic sgn, rem;
        sgn = (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
        rem = (f3 == FUNCT3_REM) || (f3 == FUNCT3_REMU);
        e.zd = 1'b0;
        e.ov = 1'b0;
        e.lat = 34;
        if (b == 0) begin
            e.res = rem ? a : 32'hFFFF_FFFF;
            e.zd = 1'b1;
            e.lat = 1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = rem ? 32'h0 : 32'h8000_0000;
            e.ov = 1'b1;
            e.lat = 1;
        end else if (sgn) begin
            e.res = rem ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        end else begin
            e.res = rem ? a % b : a / b;
        end
        return e;
    endfunction

    function automatic logic exp_stall(input int c);
        if (m_k < 0) return 1'b0;
        return (c >= m_k) && (c < m_done) && (c < m_abort);
    endfunction

    function automatic logic exp_busy(input int c);
        if (m_k < 0) return 1'b0;
        return (c > m_k) && (c <= m_done) && (c < m_abort);
    endfunction

    function automatic logic exp_done(input int c);
        if (m_k < 0) return 1'b0;
        return (c == m_done) && (c < m_abort);
    endfunction

    function automatic logic finished(input int c);
        return (m_k >= 0) && (c >= m_done) && (m_done < m_abort);
    endfunction

    function automatic logic [31:0] exp_res(input int c);
        return finished(c) ? m_new_res : m_old_res;
    endfunction

    function automatic logic exp_zd(input int c);
        if (m_k < 0 || c <= m_k) return m_old_zd;
        return finished(c) ? m_new_zd : 1'b0;
    endfunction

    function automatic logic exp_ov(input int c);
        if (m_k < 0 || c <= m_k) return m_old_ov;
        return finished(c) ? m_new_ov : 1'b0;
    endfunction

    task automatic model_start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e = model(f3, a, b);
        m_old_res = exp_res(cyc);
        m_old_zd  = exp_zd(cyc);
        m_old_ov  = exp_ov(cyc);
        m_k       = cyc;
        m_done    = cyc + e.lat;
        m_abort   = 32'h4000_0000;
        m_new_res = e.res;
        m_new_zd  = e.zd;
        m_new_ov  = e.ov;
    endtask

    task automatic model_reset();
        m_k       = -1;
        m_abort   = 32'h4000_0000;
        m_old_res = '0;
        m_old_zd  = 1'b0;
        m_old_ov  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("stall", bus.Stall, exp_stall(cyc));
            check("busy", bus.Busy, exp_busy(cyc));
            check("done", bus.Done, exp_done(cyc));
            check("result", bus.Result, exp_res(cyc));
            check("zero_div", bus.ZeroDivision, exp_zd(cyc));
            check("ovf", bus.OverflowSignedDiv, exp_ov(cyc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.Start    = 1'b1;
        bus.Funct3   = f3;
        bus.Dividend = a;
        bus.Divisor  = b;
        model_start(f3, a, b);
    endtask

    // Starts in the cycle after the call, waits for Done, then checks literals.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] lit_res, input int lit_lat,
                          input logic lit_zd, input logic lit_ov, input int inject);
        int lat;
        tick();
        drive_start(f3, a, b);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            bus.Start    = (i == inject);
            bus.Dividend = 32'hDEAD_BEEF;
            bus.Divisor  = 32'h0000_0003;
            if (i == inject) begin
                bus.Funct3   = FUNCT3_REMU;
                bus.Dividend = 32'd77;
                bus.Divisor  = 32'd0;
            end
            if (bus.Done === 1'b1) begin
                lat = i;
                break;
            end
        end
        bus.Start = 1'b0;
        check({name, " latency"}, lat, lit_lat);
        check({name, " value"}, bus.Result, lit_res);
        check({name, " zd flag"}, bus.ZeroDivision, lit_zd);
        check({name, " ovf flag"}, bus.OverflowSignedDiv, lit_ov);
    endtask

    initial begin
        int  k;
        bit  saw_done;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        cmp_en   = 1'b0;
        model_reset();
        rst_n        = 1'b0;
        bus.Start    = 1'b0;
        bus.Funct3   = 3'b000;
        bus.Dividend = '0;
        bus.Divisor  = '0;
        bus.Flush    = 1'b0;

        tick();
        tick();
        cmp_en = 1'b1;
        check("reset busy", bus.Busy, 1'b0);
        check("reset stall", bus.Stall, 1'b0);
        check("reset done", bus.Done, 1'b0);
        check("reset result", bus.Result, 32'h0);
        check("reset flags", {bus.ZeroDivision, bus.OverflowSignedDiv}, 2'b00);
        rst_n = 1'b1;

        run_op("divu 100/7", FUNCT3_DIVU, 32'd100, 32'd7, 32'd14, 34, 1'b0, 1'b0, 0);
        run_op("remu 100/7", FUNCT3_REMU, 32'd100, 32'd7, 32'd2, 34, 1'b0, 1'b0, 0);
        run_op("div -7/2", FUNCT3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b0, 1'b0, 0);
        run_op("rem -7/2", FUNCT3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b0, 1'b0, 0);
        run_op("div 7/-2", FUNCT3_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 1'b0, 1'b0, 0);
        run_op("div 1234/0", FUNCT3_DIV, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1, 1'b1, 1'b0, 0);
        run_op("remu 1234/0", FUNCT3_REMU, 32'd1234, 32'd0, 32'd1234, 1, 1'b1, 1'b0, 0);
        run_op("div ovf", FUNCT3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0, 1'b1, 0);
        run_op("rem ovf", FUNCT3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 1'b0, 1'b1, 0);
        run_op("divu big", FUNCT3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 34, 1'b0, 1'b0, 0);
        run_op("remu big", FUNCT3_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 34, 1'b0, 1'b0, 0);
        run_op("rem min/3", FUNCT3_REM, 32'h8000_0000, 32'd3, 32'hFFFF_FFFE, 34, 1'b0, 1'b0, 0);
        run_op("div -100/-7", FUNCT3_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 34, 1'b0, 1'b0, 0);
        run_op("rem 100/-7", FUNCT3_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, 34, 1'b0, 1'b0, 0);
        run_op("funct3 000", 3'b000, 32'd100, 32'd7, 32'd14, 34, 1'b0, 1'b0, 0);
        run_op("divu max/1", FUNCT3_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 1'b0, 1'b0, 0);

        // Flush ten cycles into a DIVU.
        tick();
        drive_start(FUNCT3_DIVU, 32'd1000, 32'd3);
        k = cyc;
        while (cyc < k + 10) begin
            tick();
            bus.Start = 1'b0;
        end
        bus.Flush = 1'b1;
        m_abort = cyc + 1;
        tick();
        bus.Flush = 1'b0;
        check("flush busy", bus.Busy, 1'b0);
        check("flush result kept", bus.Result, 32'hFFFF_FFFF);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.Done === 1'b1) saw_done = 1'b1;
        end
        check("flush no done", saw_done, 1'b0);

        // A Start during RUN is ignored; only the first op completes.
        run_op("start in run", FUNCT3_DIVU, 32'd5000, 32'd9, 32'd555, 34, 1'b0, 1'b0, 5);

        // Reset twenty cycles into an op, then a fresh op.
        tick();
        drive_start(FUNCT3_DIVU, 32'd1000, 32'd3);
        k = cyc;
        while (cyc < k + 20) begin
            tick();
            bus.Start = 1'b0;
        end
        rst_n = 1'b0;
        tick();
        model_reset();
        rst_n = 1'b1;
        check("mid reset busy", bus.Busy, 1'b0);
        check("mid reset stall", bus.Stall, 1'b0);
        check("mid reset result", bus.Result, 32'h0);
        run_op("after reset", FUNCT3_DIVU, 32'd1000, 32'd3, 32'd333, 34, 1'b0, 1'b0, 0);

        tick();
        tick();
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
